// File: rtl/p_sdfcn_pipe.sv
// WIDTH-bit, DEPTH-stage valid/ready retiming pipe with per-stage bubble collapse and synchronous flush.
// Define P_SDFCN_PIPE_LEVEL_EN to add the registered occupancy output `level`.
module p_sdfcn_pipe #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             CP,
    input  logic             CDN,
    input  logic             in_pvld,
    output logic             in_prdy,
    input  logic [WIDTH-1:0] in_pd,
    output logic             out_pvld,
    input  logic             out_prdy,
    output logic [WIDTH-1:0] out_pd,
    input  logic             flush
`ifdef P_SDFCN_PIPE_LEVEL_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] level
`endif
);

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] up_vld;
    logic [WIDTH-1:0] pd     [DEPTH];
    logic [WIDTH-1:0] up_pd  [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        // A stage may load when the sink is ready or any stage at or after it is empty.
        assign rdy[g] = out_prdy | ~(&vld[DEPTH-1:g]);

        if (g == 0) begin : g_head
            assign up_vld[g] = in_pvld;
            assign up_pd[g]  = in_pd;
        end else begin : g_body
            assign up_vld[g] = vld[g-1];
            assign up_pd[g]  = pd[g-1];
        end
    end

    always_ff @(posedge CP or negedge CDN) begin
        if (!CDN) begin
            for (int i = 0; i < DEPTH; i++) begin
                vld[i] <= 1'b0;
                // NOTE: data flops are reset too, so out_pd is RESET_VAL (never X) before the first entry.
                pd[i]  <= RESET_VAL;
            end
        end else if (flush) begin
            vld <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rdy[i]) begin
                    vld[i] <= up_vld[i];
                    if (up_vld[i]) pd[i] <= up_pd[i];
                end
            end
        end
    end

    assign in_prdy  = rdy[0] & ~flush & CDN;
    assign out_pvld = vld[DEPTH-1];
    assign out_pd   = pd[DEPTH-1];

`ifdef P_SDFCN_PIPE_LEVEL_EN
    localparam int LW = $clog2(DEPTH+1);

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = in_pvld & in_prdy;
    assign out_xfer = out_pvld & out_prdy;

    always_ff @(posedge CP or negedge CDN) begin
        if (!CDN) begin
            level <= '0;
        end else if (flush) begin
            level <= '0;
        end else begin
            case ({in_xfer, out_xfer})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_p_sdfcn_pipe.sv
// Self-checking bench for p_sdfcn_pipe: randomized and directed stimulus against a
// position-tracking entry model (entries compact toward the output as far as room allows).
module tb_p_sdfcn_pipe;

    localparam int         WIDTH = 8;
    localparam int         DEPTH = 3;
    localparam logic [7:0] RV    = 8'hA5;

    logic             CP       = 1'b0;
    logic             CDN      = 1'b0;
    logic             in_pvld  = 1'b0;
    logic             in_prdy;
    logic [WIDTH-1:0] in_pd    = '0;
    logic             out_pvld;
    logic             out_prdy = 1'b0;
    logic [WIDTH-1:0] out_pd;
    logic             flush    = 1'b0;
`ifdef P_SDFCN_PIPE_LEVEL_EN
    logic [$clog2(DEPTH+1)-1:0] level;
`endif

    p_sdfcn_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RV)) dut (
        .CP       (CP),
        .CDN      (CDN),
        .in_pvld  (in_pvld),
        .in_prdy  (in_prdy),
        .in_pd    (in_pd),
        .out_pvld (out_pvld),
        .out_prdy (out_prdy),
        .out_pd   (out_pd),
        .flush    (flush)
`ifdef P_SDFCN_PIPE_LEVEL_EN
        ,
        .level    (level)
`endif
    );

    always #5 CP = ~CP;

    int checks   = 0;
    int failures = 0;

    // Model: each held entry has a position 0..DEPTH-1, oldest first.
    int         m_pos[$];
    logic [7:0] m_dat[$];
    logic [7:0] m_last;
    logic [7:0] popped[$];
    int         accepted;
    int         dut_acc;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        m_pos.delete();
        m_dat.delete();
        m_last = RV;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (out_pvld !== 1'b0) begin
            failures++;
            $display("FAIL %s out_pvld got=%b exp=0", tag, out_pvld);
        end
        checks++;
        if (out_pd !== RV) begin
            failures++;
            $display("FAIL %s out_pd got=%h exp=%h", tag, out_pd, RV);
        end
        checks++;
        if (in_prdy !== 1'b0) begin
            failures++;
            $display("FAIL %s in_prdy got=%b exp=0", tag, in_prdy);
        end
`ifdef P_SDFCN_PIPE_LEVEL_EN
        checks++;
        if (level !== '0) begin
            failures++;
            $display("FAIL %s level got=%0d exp=0", tag, level);
        end
`endif
    endtask

    // One clock cycle: compare outputs at the falling edge, advance the model, return at posedge+1.
    task automatic step();
        bit exp_ovld;
        bit pop;
        bit exp_irdy;
        int np[$];
        @(negedge CP);
        exp_ovld = (m_pos.size() > 0) && (m_pos[0] == DEPTH-1);
        pop      = exp_ovld && out_prdy;
        np       = m_pos;
        if (pop) void'(np.pop_front());
        for (int k = 0; k < np.size(); k++)
            np[k] = (k == 0) ? imin(np[k] + 1, DEPTH-1) : imin(np[k] + 1, np[k-1] - 1);
        exp_irdy = !flush && ((np.size() == 0) || (np[np.size()-1] >= 1));

        checks++;
        if (in_prdy !== exp_irdy) begin
            failures++;
            $display("FAIL in_prdy t=%0t got=%b exp=%b", $time, in_prdy, exp_irdy);
        end
        checks++;
        if (out_pvld !== exp_ovld) begin
            failures++;
            $display("FAIL out_pvld t=%0t got=%b exp=%b", $time, out_pvld, exp_ovld);
        end
        checks++;
        if (out_pd !== m_last) begin
            failures++;
            $display("FAIL out_pd t=%0t got=%h exp=%h", $time, out_pd, m_last);
        end
`ifdef P_SDFCN_PIPE_LEVEL_EN
        checks++;
        if ($isunknown(level) || int'(level) != m_pos.size()) begin
            failures++;
            $display("FAIL level t=%0t got=%0d exp=%0d", $time, level, m_pos.size());
        end
`endif
        if (in_pvld && in_prdy) dut_acc++;

        if (flush) begin
            m_pos.delete();
            m_dat.delete();
        end else begin
            if (pop) popped.push_back(m_dat.pop_front());
            m_pos = np;
            if (in_pvld && exp_irdy) begin
                m_pos.push_back(0);
                m_dat.push_back(in_pd);
                accepted++;
            end
            if (m_pos.size() > 0 && m_pos[0] == DEPTH-1) m_last = m_dat[0];
        end
        @(posedge CP);
        #1;
    endtask

    task automatic drain();
        in_pvld  = 1'b0;
        flush    = 1'b0;
        out_prdy = 1'b1;
        repeat (DEPTH + 2) step();
    endtask

    task automatic check_popped(input string tag, input int idx, input logic [7:0] exp);
        checks++;
        if (idx >= popped.size()) begin
            failures++;
            $display("FAIL %s missing output #%0d exp=%h", tag, idx, exp);
        end else if (popped[idx] !== exp) begin
            failures++;
            $display("FAIL %s output #%0d got=%h exp=%h", tag, idx, popped[idx], exp);
        end
    endtask

    task automatic test_reset();
        CDN      = 1'b0;
        out_prdy = 1'b1;
        in_pvld  = 1'b1;
        in_pd    = 8'h3C;
        #12;
        check_reset_outputs("reset_low");
        @(posedge CP);
        #1;
        check_reset_outputs("reset_held");
        in_pvld = 1'b0;
        CDN     = 1'b1;
        #1;
        checks++;
        if (in_prdy !== 1'b1) begin
            failures++;
            $display("FAIL release_in_prdy got=%b exp=1", in_prdy);
        end
        model_reset();
        @(posedge CP);
        #1;
        repeat (2) step();
    endtask

    task automatic test_streaming();
        popped.delete();
        out_prdy = 1'b1;
        for (int v = 1; v <= 16; v++) begin
            in_pvld = 1'b1;
            in_pd   = 8'(v);
            step();
        end
        drain();
        checks++;
        if (popped.size() != 16) begin
            failures++;
            $display("FAIL stream_count got=%0d exp=16", popped.size());
        end
        for (int i = 0; i < 16; i++) check_popped("stream", i, 8'(i + 1));
    endtask

    task automatic test_backpressure();
        popped.delete();
        out_prdy = 1'b0;
        accepted = 0;
        dut_acc  = 0;
        for (int c = 0; c < 6; c++) begin
            in_pvld = 1'b1;
            in_pd   = 8'(accepted + 1);
            step();
        end
        checks++;
        if (dut_acc != DEPTH) begin
            failures++;
            $display("FAIL fill_accepts got=%0d exp=%0d", dut_acc, DEPTH);
        end
        out_prdy = 1'b1;
        #1;
        checks++;
        if (in_prdy !== 1'b1) begin
            failures++;
            $display("FAIL full_passthrough_rdy got=%b exp=1", in_prdy);
        end
        step();
        drain();
        for (int i = 0; i < 4; i++) check_popped("bp_order", i, 8'(i + 1));
    endtask

    task automatic test_bubble_collapse();
        popped.delete();
        out_prdy = 1'b0;
        in_pvld = 1'b1; in_pd = 8'hAA; step();
        in_pvld = 1'b0;                step();
        in_pvld = 1'b1; in_pd = 8'hBB; step();
        in_pvld = 1'b0;
        step();
        step();
        checks++;
        if (in_prdy !== 1'b1 || out_pvld !== 1'b1 || out_pd !== 8'hAA) begin
            failures++;
            $display("FAIL bubble_state in_prdy=%b out_pvld=%b out_pd=%h exp 1/1/aa",
                     in_prdy, out_pvld, out_pd);
        end
        drain();
        check_popped("bubble", 0, 8'hAA);
        check_popped("bubble", 1, 8'hBB);
    endtask

    task automatic test_flush();
        popped.delete();
        out_prdy = 1'b0;
        for (int v = 1; v <= 3; v++) begin
            in_pvld = 1'b1;
            in_pd   = 8'(8'h10 * v + v);
            step();
        end
        flush = 1'b1;
        in_pd = 8'h44;
        step();
        flush   = 1'b0;
        in_pvld = 1'b0;
        #1;
        checks++;
        if (out_pvld !== 1'b0) begin
            failures++;
            $display("FAIL flush_empty out_pvld got=%b exp=0", out_pvld);
        end
        drain();
        checks++;
        if (popped.size() != 0) begin
            failures++;
            $display("FAIL flush_leak got=%0d entries exp=0", popped.size());
        end
    endtask

    task automatic test_random();
        int prev_acc;
        popped.delete();
        accepted = 0;
        in_pvld  = 1'b0;
        for (int c = 0; c < 400; c++) begin
            prev_acc = accepted;
            out_prdy = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 31) == 0);
            if (!in_pvld) begin
                in_pvld = $urandom_range(0, 1);
                in_pd   = 8'($urandom);
            end
            step();
            if (in_pvld && accepted != prev_acc) begin
                in_pvld = $urandom_range(0, 1);
                in_pd   = 8'($urandom);
            end
        end
        drain();
    endtask

    task automatic test_async_reset();
        out_prdy = 1'b1;
        for (int v = 0; v < 4; v++) begin
            in_pvld = 1'b1;
            in_pd   = 8'(8'h60 + v);
            step();
        end
        #2;
        CDN = 1'b0;
        #1;
        check_reset_outputs("async_mid");
        model_reset();
        in_pvld = 1'b0;
        @(posedge CP);
        #1;
        CDN = 1'b1;
        popped.delete();
        repeat (DEPTH + 1) step();
        checks++;
        if (popped.size() != 0) begin
            failures++;
            $display("FAIL async_leak got=%0d entries exp=0", popped.size());
        end
        in_pvld = 1'b1; in_pd = 8'h71; step();
        in_pvld = 1'b1; in_pd = 8'h72; step();
        drain();
        check_popped("post_reset", 0, 8'h71);
        check_popped("post_reset", 1, 8'h72);
    endtask

    initial begin
        model_reset();
        accepted = 0;
        dut_acc  = 0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_bubble_collapse();
        test_flush();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
